// File: rtl/usb_sie_tx.sv
// usb_sie_tx: full-speed USB SIE transmit path.
// Takes packet bytes from the protocol engine over a tx_data/tx_valid/tx_ready
// handshake and serializes them LSB-first onto D+/D-, adding SYNC, NRZI
// encoding, bit stuffing and EOP.
// Optional feature: define USB_SIE_TX_ABORT_EN to add the tx_abort input,
// which ends a packet with a deliberate bit-stuff error followed by EOP.
module usb_sie_tx #(
  parameter int unsigned CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef USB_SIE_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       tx_active,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oe
);

  localparam int unsigned TW          = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST    = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE     = TW'(CLK_PER_BIT - 2);
  localparam logic [2:0]    ONES_STUFF = 3'd6;
  localparam logic [2:0]    ABORT_LAST = 3'd6;
  localparam logic [2:0]    SE0_LAST   = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
`ifdef USB_SIE_TX_ABORT_EN
    ST_ABORT,
`endif
    ST_EOP_J
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bitcnt;   // bit index within the current byte, or EOP/abort bit count
  logic [2:0]    r_ones;     // consecutive ones launched on the line
  logic [7:0]    r_shift;    // remaining data bits, next bit in [0]
  logic          r_line;     // current NRZI level, 1 = J, 0 = K
  logic          r_oe;
  logic          r_dp;
  logic          r_dn;
  logic          r_ready;
  logic          r_active;
`ifdef USB_SIE_TX_ABORT_EN
  logic          r_abort_pend;
`endif

  logic w_strobe;
  logic w_in_ser;
  logic w_stuff_due;
  logic w_byte_end;
  logic w_boundary;
  logic w_next_bit;
  logic w_next_level;
  logic w_load_level;
  logic w_abort;

  // Bit timing and serializer decode of the registered state
  assign w_strobe     = (r_state != ST_IDLE) && (r_timer == T_LAST);
  assign w_in_ser     = (r_state == ST_SYNC) || (r_state == ST_DATA);
  assign w_stuff_due  = (r_ones == ONES_STUFF);
  assign w_byte_end   = (r_bitcnt == 3'd7);
  assign w_boundary   = w_byte_end && !w_stuff_due;
  // SYNC is 0x80 LSB-first: only its eighth bit is a one
  assign w_next_bit   = (r_state == ST_SYNC) ? (r_bitcnt == 3'd6) : r_shift[0];
  assign w_next_level = w_next_bit ? r_line : ~r_line;
  assign w_load_level = tx_data[0] ? r_line : ~r_line;
`ifdef USB_SIE_TX_ABORT_EN
  assign w_abort      = r_abort_pend | tx_abort;
`else
  assign w_abort      = 1'b0;
`endif

  // Transmit FSM: bit timer, SYNC/data/stuff launch, EOP and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_bitcnt     <= '0;
      r_ones       <= '0;
      r_shift      <= '0;
      r_line       <= 1'b1;
      r_oe         <= 1'b0;
      r_dp         <= 1'b1;
      r_dn         <= 1'b0;
      r_ready      <= 1'b0;
      r_active     <= 1'b0;
`ifdef USB_SIE_TX_ABORT_EN
      r_abort_pend <= 1'b0;
`endif
    end else begin
      // Ready is raised one clk ahead so it is high during the boundary strobe clk
      r_ready <= 1'b0;
      if (w_in_ser && (r_timer == T_PRE) && w_boundary && !w_abort) begin
        r_ready <= 1'b1;
      end

      if (r_state != ST_IDLE) begin
        r_timer <= w_strobe ? '0 : r_timer + TW'(1);
      end

`ifdef USB_SIE_TX_ABORT_EN
      if (w_in_ser && tx_abort) begin
        r_abort_pend <= 1'b1;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (tx_valid) begin
            // First SYNC bit is a zero: toggle from idle J to K
            r_state  <= ST_SYNC;
            r_oe     <= 1'b1;
            r_active <= 1'b1;
            r_bitcnt <= '0;
            r_ones   <= '0;
            r_line   <= 1'b0;
            r_dp     <= 1'b0;
            r_dn     <= 1'b1;
          end
        end

        ST_SYNC, ST_DATA: begin
          if (w_strobe) begin
`ifdef USB_SIE_TX_ABORT_EN
            if (w_abort) begin
              // Current bit has completed; hold the level from here on
              r_state      <= ST_ABORT;
              r_bitcnt     <= '0;
              r_abort_pend <= 1'b0;
            end else
`endif
            if (w_stuff_due) begin
              // Inserted zero: toggle, counter clears, bit index unchanged
              r_line <= ~r_line;
              r_dp   <= ~r_line;
              r_dn   <= r_line;
              r_ones <= '0;
            end else if (w_byte_end) begin
              if (tx_valid) begin
                r_state  <= ST_DATA;
                r_bitcnt <= '0;
                r_shift  <= {1'b0, tx_data[7:1]};
                r_line   <= w_load_level;
                r_dp     <= w_load_level;
                r_dn     <= ~w_load_level;
                r_ones   <= tx_data[0] ? r_ones + 3'd1 : '0;
              end else begin
                r_state  <= ST_EOP_SE0;
                r_bitcnt <= '0;
                r_dp     <= 1'b0;
                r_dn     <= 1'b0;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_line   <= w_next_level;
              r_dp     <= w_next_level;
              r_dn     <= ~w_next_level;
              r_ones   <= w_next_bit ? r_ones + 3'd1 : '0;
              if (r_state == ST_DATA) begin
                r_shift <= {1'b0, r_shift[7:1]};
              end
            end
          end
        end

`ifdef USB_SIE_TX_ABORT_EN
        ST_ABORT: begin
          // Seven bit times at a constant level, then the normal EOP
          if (w_strobe) begin
            if (r_bitcnt == ABORT_LAST) begin
              r_state  <= ST_EOP_SE0;
              r_bitcnt <= '0;
              r_dp     <= 1'b0;
              r_dn     <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
`endif

        ST_EOP_SE0: begin
          if (w_strobe) begin
            if (r_bitcnt == SE0_LAST) begin
              r_state  <= ST_EOP_J;
              r_bitcnt <= '0;
              r_dp     <= 1'b1;
              r_dn     <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end

        ST_EOP_J: begin
          if (w_strobe) begin
            r_state  <= ST_IDLE;
            r_oe     <= 1'b0;
            r_active <= 1'b0;
            r_dp     <= 1'b1;
            r_dn     <= 1'b0;
            r_line   <= 1'b1;
            r_bitcnt <= '0;
            r_ones   <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = r_ready;
  assign tx_active = r_active;
  assign dp_tx     = r_dp;
  assign dn_tx     = r_dn;
  assign tx_oe     = r_oe;

endmodule

// File: tb/tb_usb_sie_tx.sv
// tb_usb_sie_tx: table-driven bench for usb_sie_tx at CLK_PER_BIT=4.
// Each packet is captured clk by clk while tx_oe is high, then NRZI-decoded,
// unstuffed and compared against hand-computed lengths, ready spacing and bytes.
module tb_usb_sie_tx;

  localparam int CPB  = 4;
  localparam int MAXC = 1024;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_active;
  logic       dp_tx;
  logic       dn_tx;
  logic       tx_oe;
`ifdef USB_SIE_TX_ABORT_EN
  logic       tx_abort;
`endif

  int n_vec;
  int n_err;

  logic [1:0] cap_line [MAXC];
  int         cap_n;
  int         rdy_idx [16];
  int         rdy_n;
  int         dbl_rdy;

  typedef struct {
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    int         raw_bits;
    int         oe_clks;
    int         readies;
    int         gap;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  usb_sie_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
`ifdef USB_SIE_TX_ABORT_EN
    .tx_abort  (tx_abort),
`endif
    .tx_ready  (tx_ready),
    .tx_active (tx_active),
    .dp_tx     (dp_tx),
    .dn_tx     (dn_tx),
    .tx_oe     (tx_oe)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one packet through the handshake and record the line while tx_oe is high
  task automatic run_capture(input int nb, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input int abort_rel, input string tag);
    logic [7:0] d [3];
    int  k;
    bit  started;
    bit  done;
    bit  adv;
    bit  prev_rdy;
    int  cur;
    d[0] = d0; d[1] = d1; d[2] = d2;
    cap_n = 0; rdy_n = 0; dbl_rdy = 0;
    k = 0; started = 0; done = 0; adv = 0; prev_rdy = 0;
    tx_data  = d0;
    tx_valid = 1'b1;
    for (int cyc = 0; cyc < MAXC && !done; cyc++) begin
      @(posedge clk); #1;
`ifdef USB_SIE_TX_ABORT_EN
      tx_abort = 1'b0;
`endif
      if (cyc == 0 && nb == 0) tx_valid = 1'b0;
      if (adv) begin
        k++;
        if (k < 3) tx_data = d[k];
        tx_valid = (k < nb);
        adv = 0;
      end
      if (tx_oe) begin
        started = 1;
        cap_line[cap_n] = {dp_tx, dn_tx};
        cur = cap_n;
        cap_n++;
        if (tx_ready) begin
          if (prev_rdy) dbl_rdy++;
          if (rdy_n < 16) rdy_idx[rdy_n] = cur;
          rdy_n++;
          adv = 1;
        end
        prev_rdy = tx_ready;
`ifdef USB_SIE_TX_ABORT_EN
        if (abort_rel > 0 && rdy_n >= 2 && cur == rdy_idx[1] + abort_rel) tx_abort = 1'b1;
`endif
      end else if (started) begin
        done = 1;
      end
    end
    tx_valid = 1'b0;
    check($sformatf("%s_done", tag), int'(done), 1);
  endtask

  // Decode the captured packet and compare against the vector's expectations
  task automatic check_normal(input vec_t v, input string tag);
    logic [1:0] sync_exp [8];
    logic [7:0] exp_b [3];
    logic [7:0] got [4];
    logic [7:0] cur;
    logic [1:0] prev;
    logic [1:0] lv;
    logic       bv;
    int bad, se0_start, se0_len, j_len, ones, nbytes, bitpos, stuffbad;
    sync_exp[0] = LK; sync_exp[1] = LJ; sync_exp[2] = LK; sync_exp[3] = LJ;
    sync_exp[4] = LK; sync_exp[5] = LJ; sync_exp[6] = LK; sync_exp[7] = LK;
    exp_b[0] = v.d0; exp_b[1] = v.d1; exp_b[2] = v.d2;
    cur = '0;
    for (int i = 0; i < 4; i++) got[i] = '0;

    bad = 0;
    for (int i = 0; i < cap_n; i++) if (cap_line[i] !== cap_line[(i / CPB) * CPB]) bad++;
    check($sformatf("%s_bit_width", tag), bad, 0);
    check($sformatf("%s_oe_clks", tag), cap_n, v.oe_clks);
    check($sformatf("%s_ready_cnt", tag), rdy_n, v.readies);
    check($sformatf("%s_ready_width", tag), dbl_rdy, 0);

    bad = 0;
    for (int b = 0; b < 8; b++) begin
      if (b * CPB >= cap_n) bad++;
      else if (cap_line[b * CPB] !== sync_exp[b]) bad++;
    end
    check($sformatf("%s_sync", tag), bad, 0);

    se0_start = -1;
    for (int i = 0; i < cap_n; i++) if (se0_start < 0 && cap_line[i] == LSE0) se0_start = i;
    if (se0_start < 8 * CPB) begin
      check($sformatf("%s_se0_start", tag), se0_start, v.raw_bits * CPB);
      return;
    end
    check($sformatf("%s_raw_bits", tag), se0_start / CPB, v.raw_bits);
    if (rdy_n > 0 && rdy_n <= 16)
      check($sformatf("%s_se0_after_ready", tag), se0_start, rdy_idx[rdy_n - 1] + 1);

    se0_len = 0;
    for (int i = se0_start; i < cap_n && cap_line[i] == LSE0; i++) se0_len++;
    check($sformatf("%s_se0_len", tag), se0_len, 2 * CPB);
    j_len = 0;
    for (int i = se0_start + 2 * CPB; i < cap_n; i++) if (cap_line[i] == LJ) j_len++;
    check($sformatf("%s_eop_j_len", tag), j_len, CPB);

    prev = cap_line[7 * CPB];
    ones = 1;
    nbytes = 0; bitpos = 0; stuffbad = 0;
    for (int b = 8; b < se0_start / CPB; b++) begin
      lv = cap_line[b * CPB];
      bv = (lv == prev);
      prev = lv;
      if (ones == 6) begin
        if (bv) stuffbad++;
        ones = 0;
      end else begin
        ones = bv ? ones + 1 : 0;
        cur[bitpos] = bv;
        bitpos++;
        if (bitpos == 8) begin
          if (nbytes < 4) got[nbytes] = cur;
          nbytes++;
          bitpos = 0;
        end
      end
    end
    check($sformatf("%s_stuff_bits", tag), stuffbad, 0);
    check($sformatf("%s_partial_bits", tag), bitpos, 0);
    check($sformatf("%s_byte_cnt", tag), nbytes, v.nb);
    for (int j = 0; j < v.nb && j < 3; j++)
      check($sformatf("%s_byte%0d", tag, j), int'(got[j]), int'(exp_b[j]));
    if (v.gap > 0)
      for (int j = 1; j < rdy_n && j < 16; j++)
        check($sformatf("%s_ready_gap%0d", tag, j), rdy_idx[j] - rdy_idx[j - 1], v.gap);
  endtask

  initial begin
    int idle_oe;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
`ifdef USB_SIE_TX_ABORT_EN
    tx_abort = 1'b0;
`endif
    //         nb  d0     d1     d2     raw oe   rdy gap
    vecs[0] = '{1, 8'hA5, 8'h00, 8'h00, 16, 76,  2, 32};
    vecs[1] = '{2, 8'hFF, 8'hFF, 8'h00, 26, 116, 3, 36};
    vecs[2] = '{3, 8'h00, 8'h01, 8'h02, 32, 140, 4, 32};
    vecs[3] = '{1, 8'hFC, 8'h00, 8'h00, 17, 80,  2, 36};
    vecs[4] = '{0, 8'h00, 8'h00, 8'h00, 8,  44,  1, 0};
    vecs[5] = '{2, 8'hF0, 8'h03, 8'h00, 25, 112, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({tx_oe, dp_tx, dn_tx, tx_ready, tx_active}), int'(5'b01000));
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_outputs", int'({tx_oe, dp_tx, dn_tx, tx_ready, tx_active}), int'(5'b01000));

    // Packets run back to back with no idle gap between them
    for (int i = 0; i < 6; i++) begin
      run_capture(vecs[i].nb, vecs[i].d0, vecs[i].d1, vecs[i].d2, 0, $sformatf("v%0d", i));
      check_normal(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted asynchronously in the middle of a data byte
    repeat (2) @(posedge clk);
    #1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_data", int'({tx_oe, dp_tx, dn_tx, tx_ready, tx_active}), int'(5'b01000));
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_oe = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_oe || !dp_tx || dn_tx) idle_oe++;
    end
    check("rst_release_idle", idle_oe, 0);
    run_capture(vecs[0].nb, vecs[0].d0, vecs[0].d1, vecs[0].d2, 0, "post_rst");
    check_normal(vecs[0], "post_rst");

`ifdef USB_SIE_TX_ABORT_EN
    // Abort during the third bit of byte two: hold 28 clks after that bit, then EOP
    begin
      int r, se0_start, bad;
      repeat (2) @(posedge clk);
      #1;
      run_capture(3, 8'h00, 8'h00, 8'h00, 10, "abort");
      check("abort_ready_cnt", rdy_n, 2);
      if (rdy_n >= 2) begin
        r = rdy_idx[1];
        se0_start = -1;
        for (int i = 0; i < cap_n; i++) if (se0_start < 0 && cap_line[i] == LSE0) se0_start = i;
        check("abort_se0_start", se0_start, r + 41);
        bad = 0;
        if (r + 41 < MAXC)
          for (int i = r + 13; i <= r + 40; i++) if (cap_line[i] !== cap_line[r + 12]) bad++;
        check("abort_hold_level", bad, 0);
        check("abort_oe_clks", cap_n, r + 41 + 3 * CPB);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
